prng_range: RTL and testbench

Parametrised pseudo-random source for the snake game, replacing the fixed 16-stage single-bit LFSR chain. It holds a WIDTH-bit Galois LFSR with seed load and lock-up protection, and exposes a free-running serial bit. It also serves range-limited random values through a valid/ready request/response handshake, for example food placement within a grid dimension. Rejection sampling keeps those values uniform.

---
 rtl/prng_pkg.sv | 22 ++
 rtl/lfsr_core.sv | 40 ++++
 rtl/prng_range.sv | 118 +++++++++++
 tb/tb_prng_range.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// prng_pkg: shared definitions for the snake-game pseudo-random source.
//   - prng_state_e : request FSM states (IDLE / DRAW / HOLD)
//   - TAPS_* / SEED_* : default Galois feedback masks and reset seeds for
//     the common LFSR widths 8, 16 and 32. Each mask is maximal-length and
//     each seed is non-zero.
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a request, req_ready high
        DRAW = 2'd1,   // evaluating one candidate per cycle
        HOLD = 2'd2    // response presented until the consumer takes it
    } prng_state_e;

    // Bit k of a mask corresponds to the x^(k+1) term of the polynomial.
    localparam logic [7:0]  TAPS_8  = 8'hB8;          // x^8+x^6+x^5+x^4+1
    localparam logic [7:0]  SEED_8  = 8'hE1;
    localparam logic [15:0] TAPS_16 = 16'hB400;       // x^16+x^14+x^13+x^11+1
    localparam logic [15:0] SEED_16 = 16'hACE1;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;  // x^32+x^22+x^2+x+1
    localparam logic [31:0] SEED_32 = 32'hACE1_2468;

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: WIDTH-bit right-shifting Galois LFSR.
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset, state <= SEED
//   load       in   load load_value this cycle (highest priority)
//   load_value in   value to load; zero is replaced by SEED
//   step       in   advance one step this cycle when not loading
//   state      out  current LFSR state, never zero
module lfsr_core
    import prng_pkg::*;
#(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS = TAPS_16,
    parameter logic [WIDTH-1:0] SEED = SEED_16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    // The all-zero state is the lock-up point of an XOR LFSR, so a zero
    // load is turned into the reset seed instead.
    logic [WIDTH-1:0] safe_load;
    assign safe_load = (load_value == '0) ? SEED : load_value;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEED;
        end else if (load) begin
            state <= safe_load;
        end else if (step) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/prng_range.sv
// prng_range: pseudo-random source with a free-running serial bit and
// range-limited values served over a valid/ready request/response pair.
// Values are made uniform in [0, limit) by rejection sampling the low
// OUT_W bits of the LFSR; after MAX_TRIES rejections the fallback value 0
// is returned with rsp_fallback set.
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   step_en          advance the LFSR this cycle (entropy from game timing)
//   seed_load        load seed_value (zero is replaced by SEED)
//   seed_value       seed to load
//   req_valid/ready  request handshake; req_ready decodes the IDLE state
//   req_limit        exclusive upper bound, 0 means full 2^OUT_W range
//   rsp_valid/ready  response handshake
//   rsp_data         random value, rsp_fallback marks the fallback 0
//   rand_bit         lfsr_state[0]
//   lfsr_state       current LFSR state
module prng_range
    import prng_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = TAPS_16,
    parameter logic [WIDTH-1:0] SEED      = SEED_16,
    parameter int               OUT_W     = 6,
    parameter int               MAX_TRIES = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             step_en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_value,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W:0]   req_limit,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic             rsp_fallback,
    output logic             rand_bit,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam int TRIES_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

    prng_state_e        fsm_q;
    logic [OUT_W:0]     limit_q;
    logic [TRIES_W-1:0] tries_q;
    logic [OUT_W-1:0]   candidate;
    logic               accept;

    // Every DRAW cycle consumes one LFSR step, so successive candidates
    // are successive states even when the game is not stepping.
    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (seed_load),
        .load_value (seed_value),
        .step       (step_en || (fsm_q == DRAW)),
        .state      (lfsr_state)
    );

    assign rand_bit  = lfsr_state[0];
    assign req_ready = (fsm_q == IDLE);

    // The candidate is the pre-step state of this cycle. A latched limit
    // above 2^OUT_W accepts everything because the candidate cannot reach it.
    assign candidate = lfsr_state[OUT_W-1:0];
    assign accept    = (limit_q == '0) || ({1'b0, candidate} < limit_q);

    // NOTE: every control and response register is reset, so an abort
    // mid-DRAW or mid-HOLD leaves no stale response visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q        <= IDLE;
            limit_q      <= '0;
            tries_q      <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_fallback <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (req_valid) begin
                        limit_q <= req_limit;
                        tries_q <= '0;
                        fsm_q   <= DRAW;
                    end
                end
                DRAW: begin
                    if (accept) begin
                        rsp_data     <= candidate;
                        rsp_fallback <= 1'b0;
                        rsp_valid    <= 1'b1;
                        fsm_q        <= HOLD;
                    end else if (tries_q == LAST_TRY) begin
                        rsp_data     <= '0;
                        rsp_fallback <= 1'b1;
                        rsp_valid    <= 1'b1;
                        fsm_q        <= HOLD;
                    end else begin
                        tries_q <= tries_q + TRIES_W'(1);
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        fsm_q     <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prng_range.sv
// tb_prng_range: self-checking bench for prng_range. Instance u_dut uses the
// default parameters; u_dut_b uses MAX_TRIES=2 for the fallback cases.
module tb_prng_range;

    localparam int W  = 16;
    localparam int OW = 6;

    logic          clock = 1'b0;
    logic          reset_n;
    always #5 clock = ~clock;

    logic          step_en, seed_load, req_valid, rsp_ready;
    logic [W-1:0]  seed_value;
    logic [OW:0]   req_limit;
    logic          req_ready, rsp_valid, rsp_fallback, rand_bit;
    logic [OW-1:0] rsp_data;
    logic [W-1:0]  lfsr_state;

    logic          step_en_b, seed_load_b, req_valid_b, rsp_ready_b;
    logic [W-1:0]  seed_value_b;
    logic [OW:0]   req_limit_b;
    logic          req_ready_b, rsp_valid_b, rsp_fallback_b, rand_bit_b;
    logic [OW-1:0] rsp_data_b;
    logic [W-1:0]  lfsr_state_b;

    prng_range u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .step_en      (step_en),
        .seed_load    (seed_load),
        .seed_value   (seed_value),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_limit    (req_limit),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_fallback (rsp_fallback),
        .rand_bit     (rand_bit),
        .lfsr_state   (lfsr_state)
    );

    prng_range #(.MAX_TRIES(2)) u_dut_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .step_en      (step_en_b),
        .seed_load    (seed_load_b),
        .seed_value   (seed_value_b),
        .req_valid    (req_valid_b),
        .req_ready    (req_ready_b),
        .req_limit    (req_limit_b),
        .rsp_valid    (rsp_valid_b),
        .rsp_ready    (rsp_ready_b),
        .rsp_data     (rsp_data_b),
        .rsp_fallback (rsp_fallback_b),
        .rand_bit     (rand_bit_b),
        .lfsr_state   (lfsr_state_b)
    );

    typedef struct packed {
        logic [OW-1:0] data;
        logic          fb;
    } rsp_t;

    typedef struct {
        logic [OW:0]   limit;
        logic [OW-1:0] data;
        logic          fb;
        int            lat;
        int            hold;
    } vec_t;

    rsp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic sample(input bit b, output logic rv, output logic rr,
                          output logic [OW-1:0] d, output logic f, output logic [W-1:0] st);
        rv = b ? rsp_valid_b    : rsp_valid;
        rr = b ? req_ready_b    : req_ready;
        d  = b ? rsp_data_b     : rsp_data;
        f  = b ? rsp_fallback_b : rsp_fallback;
        st = b ? lfsr_state_b   : lfsr_state;
    endtask

    task automatic set_rsp_ready(input bit b, input logic v);
        if (b) rsp_ready_b = v;
        else   rsp_ready   = v;
    endtask

    // Drive one request, measure its latency, compare against the scoreboard,
    // hold off the consumer for 'hold' cycles, then complete the handshake.
    task automatic request(input bit b, input logic [OW:0] lim, input rsp_t exp_rsp,
                           input int exp_lat, input int hold, input string tag);
        logic rv, rr, f;
        logic [OW-1:0] d;
        logic [W-1:0] st;
        rsp_t exp;
        int lat;
        sample(b, rv, rr, d, f, st);
        check({tag, " req_ready before"}, 32'(rr), 32'd1);
        if (b) begin req_valid_b = 1'b1; req_limit_b = lim; end
        else   begin req_valid   = 1'b1; req_limit   = lim; end
        sb_q.push_back(exp_rsp);
        tick();
        req_valid = 1'b0;
        req_valid_b = 1'b0;
        lat = 0;
        rv = 1'b0;
        while (lat < 40 && !rv) begin
            tick();
            lat++;
            sample(b, rv, rr, d, f, st);
        end
        exp = sb_q.pop_front();
        check({tag, " rsp_valid within bound"}, 32'(rv), 32'd1);
        if (!rv) return;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rsp_data"}, 32'(d), 32'(exp.data));
        check({tag, " rsp_fallback"}, 32'(f), 32'(exp.fb));
        check({tag, " req_ready while rsp_valid"}, 32'(rr), 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            sample(b, rv, rr, d, f, st);
            check({tag, " held rsp_valid"}, 32'(rv), 32'd1);
            check({tag, " held rsp_data"}, 32'(d), 32'(exp.data));
        end
        set_rsp_ready(b, 1'b1);
        tick();
        set_rsp_ready(b, 1'b0);
        sample(b, rv, rr, d, f, st);
        check({tag, " rsp_valid after handshake"}, 32'(rv), 32'd0);
        check({tag, " req_ready after handshake"}, 32'(rr), 32'd1);
    endtask

    function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    vec_t vecs[9];
    logic [W-1:0] seq_exp[5];

    initial begin
        logic rv, rr, f;
        logic [OW-1:0] d;
        logic [W-1:0] st, m;
        int ret_at;
        logic zero_seen;
        rsp_t r;

        step_en = 0; seed_load = 0; seed_value = '0; req_valid = 0;
        req_limit = '0; rsp_ready = 0;
        step_en_b = 0; seed_load_b = 0; seed_value_b = '0; req_valid_b = 0;
        req_limit_b = '0; rsp_ready_b = 0;

        // Expected values hand-derived from seed 0xACE1: candidates are
        // 33, 48, 56, 28, 14 on successive draws.
        vecs[0] = '{limit: 7'd40, data: 6'd33, fb: 1'b0, lat: 1, hold: 0};
        vecs[1] = '{limit: 7'd20, data: 6'd14, fb: 1'b0, lat: 5, hold: 3};
        vecs[2] = '{limit: 7'd0,  data: 6'd33, fb: 1'b0, lat: 1, hold: 1};
        vecs[3] = '{limit: 7'd34, data: 6'd33, fb: 1'b0, lat: 1, hold: 0};
        vecs[4] = '{limit: 7'd33, data: 6'd28, fb: 1'b0, lat: 4, hold: 0};
        vecs[5] = '{limit: 7'd29, data: 6'd28, fb: 1'b0, lat: 4, hold: 0};
        vecs[6] = '{limit: 7'd28, data: 6'd14, fb: 1'b0, lat: 5, hold: 0};
        vecs[7] = '{limit: 7'd64, data: 6'd33, fb: 1'b0, lat: 1, hold: 0};
        vecs[8] = '{limit: 7'd100, data: 6'd33, fb: 1'b0, lat: 1, hold: 0};
        seq_exp = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27};

        // Reset state
        do_reset();
        check("reset lfsr_state", 32'(lfsr_state), 32'hACE1);
        check("reset rand_bit", 32'(rand_bit), 32'd1);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        check("reset rsp_fallback", 32'(rsp_fallback), 32'd0);

        // Free-running sequence and full period
        step_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("step %0d lfsr_state", i + 1), 32'(lfsr_state), 32'(seq_exp[i]));
        end
        ret_at = -1;
        zero_seen = 1'b0;
        for (int n = 6; n <= 65535; n++) begin
            tick();
            if (lfsr_state == '0) zero_seen = 1'b1;
            if (lfsr_state == 16'hACE1 && ret_at < 0) ret_at = n;
        end
        step_en = 1'b0;
        check("period return step", 32'(ret_at), 32'd65535);
        check("zero state seen", 32'(zero_seen), 32'd0);

        // Table-driven requests, each from a fresh reset
        foreach (vecs[i]) begin
            do_reset();
            request(1'b0, vecs[i].limit, '{data: vecs[i].data, fb: vecs[i].fb},
                    vecs[i].lat, vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Limit 1 accepts only 0 on the first draw
        do_reset();
        seed_load = 1'b1; seed_value = 16'h1240;
        tick();
        seed_load = 1'b0;
        check("seed load 0x1240", 32'(lfsr_state), 32'h1240);
        request(1'b0, 7'd1, '{data: 6'd0, fb: 1'b0}, 1, 0, "limit1");

        // seed_load during DRAW supplies the next candidate
        do_reset();
        req_valid = 1'b1; req_limit = 7'd20;
        sb_q.push_back('{data: 6'd5, fb: 1'b0});
        tick();
        req_valid = 1'b0;
        seed_load = 1'b1; seed_value = 16'h0005;
        tick();
        seed_load = 1'b0;
        check("draw-load rsp_valid early", 32'(rsp_valid), 32'd0);
        tick();
        r = sb_q.pop_front();
        check("draw-load rsp_valid", 32'(rsp_valid), 32'd1);
        check("draw-load rsp_data", 32'(rsp_data), 32'(r.data));
        check("draw-load rsp_fallback", 32'(rsp_fallback), 32'(r.fb));
        check("draw-load lfsr stepped", 32'(lfsr_state), 32'hB402);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Zero seed and fallback on the MAX_TRIES=2 instance
        do_reset();
        step_en_b = 1'b1;
        tick();
        tick();
        step_en_b = 1'b0;
        seed_load_b = 1'b1; seed_value_b = '0;
        tick();
        seed_load_b = 1'b0;
        check("zero seed load", 32'(lfsr_state_b), 32'hACE1);
        check("zero seed rand_bit", 32'(rand_bit_b), 32'd1);
        request(1'b1, 7'd20, '{data: 6'd0, fb: 1'b1}, 2, 1, "fallback");

        // A load mid-DRAW does not restart the try count
        do_reset();
        req_valid_b = 1'b1; req_limit_b = 7'd20;
        sb_q.push_back('{data: 6'd0, fb: 1'b1});
        tick();
        req_valid_b = 1'b0;
        seed_load_b = 1'b1; seed_value_b = 16'h0030;
        tick();
        seed_load_b = 1'b0;
        tick();
        r = sb_q.pop_front();
        check("tries kept rsp_valid", 32'(rsp_valid_b), 32'd1);
        check("tries kept rsp_fallback", 32'(rsp_fallback_b), 32'(r.fb));
        check("tries kept rsp_data", 32'(rsp_data_b), 32'(r.data));

        // Asynchronous reset during DRAW
        do_reset();
        req_valid = 1'b1; req_limit = 7'd20;
        tick();
        req_valid = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("abort draw req_ready", 32'(req_ready), 32'd1);
        check("abort draw lfsr_state", 32'(lfsr_state), 32'hACE1);
        check("abort draw rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        request(1'b0, 7'd40, '{data: 6'd33, fb: 1'b0}, 1, 0, "after abort");

        // Asynchronous reset during HOLD
        do_reset();
        req_valid = 1'b1; req_limit = 7'd40;
        tick();
        req_valid = 1'b0;
        tick();
        check("hold before abort rsp_valid", 32'(rsp_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort hold rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort hold rsp_data", 32'(rsp_data), 32'd0);
        check("abort hold req_ready", 32'(req_ready), 32'd1);
        tick();
        reset_n = 1'b1;

        // Back-to-back requests against a reference model
        do_reset();
        m = 16'hACE1;
        for (int k = 0; k < 12; k++) begin
            logic [OW:0] lim;
            int lat;
            logic [OW-1:0] c;
            lim = (k == 3) ? 7'd1 : 7'($urandom_range(0, 70));
            r = '{data: 6'd0, fb: 1'b1};
            lat = 16;
            for (int t = 0; t < 16; t++) begin
                c = m[OW-1:0];
                m = model_step(m);
                if (lim == 0 || {1'b0, c} < lim) begin
                    r = '{data: c, fb: 1'b0};
                    lat = t + 1;
                    break;
                end
            end
            request(1'b0, lim, r, lat, 0, $sformatf("model%0d lim%0d", k, lim));
            check($sformatf("model%0d lfsr_state", k), 32'(lfsr_state), 32'(m));
        end

        check("scoreboard empty", 32'(sb_q.size()), 32'd0);
        sample(1'b0, rv, rr, d, f, st);
        check("final req_ready", 32'(rr), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
